// File: rtl/phase_timer_sequencer_pkg.sv
// Shared types and default parameter values for the phase timer sequencer.
package phase_timer_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth     = 8;
  localparam int unsigned DefaultNumPhases = 4;
  localparam int unsigned DefaultPw        = 2;
  localparam int unsigned DefaultMax       = 200;

endpackage

// File: rtl/phase_timer_sequencer_phase_max_table.sv
// Per-phase maximum count table: one synchronous write port, combinational read.
module phase_max_table import phase_timer_sequencer_pkg::*; #(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned NUM_PHASES  = DefaultNumPhases,
  parameter int unsigned PW          = DefaultPw,
  parameter int unsigned DEFAULT_MAX = DefaultMax
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned IW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [WIDTH-1:0] mem_q [NUM_PHASES];
  logic             wr_ok;

  // Out-of-range addresses must not alias onto a valid entry.
  assign wr_ok = we && (32'(waddr) < NUM_PHASES);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(NUM_PHASES); i++) begin
        mem_q[i] <= WIDTH'(DEFAULT_MAX);
      end
    end else if (wr_ok) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[raddr[IW-1:0]];

endmodule

// File: rtl/phase_timer_sequencer.sv
// Runs one up-counter through a chain of timed phases, each with its own programmable max.
module phase_timer_sequencer import phase_timer_sequencer_pkg::*; #(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned NUM_PHASES  = DefaultNumPhases,
  parameter int unsigned PW          = DefaultPw,
  parameter int unsigned DEFAULT_MAX = DefaultMax
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic             cfg_we,
  input  logic [PW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             busy,
  output logic [PW-1:0]    phase,
  output logic [WIDTH-1:0] count,
  output logic             phase_tick,
  output logic             done
);

  localparam logic [PW-1:0] LastPhase = PW'(NUM_PHASES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] cur_max;

  phase_max_table #(
    .WIDTH       (WIDTH),
    .NUM_PHASES  (NUM_PHASES),
    .PW          (PW),
    .DEFAULT_MAX (DEFAULT_MAX)
  ) u_table (
    .clk   (clk),
    .RST   (RST),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (phase),
    .rdata (cur_max)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      phase      <= '0;
      count      <= '0;
      phase_tick <= 1'b0;
      done       <= 1'b0;
    end else begin
      phase_tick <= 1'b0;
      done       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          phase <= '0;
          count <= '0;
          if (start && !abort) begin
            state_q <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            phase   <= '0;
            count   <= '0;
          end else if (count < cur_max) begin
            count <= count + WIDTH'(1);
          end else begin
            // Terminal also covers a max rewritten below the running count.
            count      <= '0;
            phase_tick <= 1'b1;
            if (phase != LastPhase) begin
              phase <= phase + PW'(1);
            end else if (loop_en) begin
              phase <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
              phase   <= '0;
              done    <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
